// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: sequence numbers, the AGU micro-op and branch
// bundles seen by the queue, and the per-slot entry record.
// Also provides helpers for ordering comparisons between wrapping sequence numbers.
package store_queue_pkg;

  localparam int unsigned SqnWidth = 7;
  localparam int unsigned SQ_SIZE  = 8;

  typedef logic [SqnWidth-1:0] SqN;
  typedef logic [29:0]         WordAddr;

  typedef struct packed {
    logic        valid;
    logic        isLoad;
    logic        exception;
    logic [31:0] addr;
    logic [31:0] data;      // already shifted into byte lanes
    logic [3:0]  wmask;
    SqN          sqN;
    SqN          storeSqN;
  } AGU_UOp;

  typedef struct packed {
    logic taken;
    SqN   sqN;
    SqN   storeSqN;
  } BranchProv;

  typedef struct packed {
    logic        valid;
    logic        committed;
    SqN          sqN;
    WordAddr     addr;
    logic [31:0] data;
    logic [3:0]  wmask;
  } SQEntry;

  // a is strictly older than b in wrapping order
  function automatic logic sqn_before(SqN a, SqN b);
    SqN d;
    d = a - b;
    return d[SqnWidth-1];
  endfunction

  // a is strictly younger than b in wrapping order
  function automatic logic sqn_after(SqN a, SqN b);
    SqN d;
    d = a - b;
    return !d[SqnWidth-1] && (d != '0);
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Data-memory write port between the store queue (master) and memory (slave).
//   valid  master->slave  write request
//   ready  slave->master  write accepted this cycle
//   addr   master->slave  word address
//   data   master->slave  byte-lane aligned store data
//   wmask  master->slave  byte enables
interface store_queue_if;
  import store_queue_pkg::*;

  logic        valid;
  logic        ready;
  WordAddr     addr;
  logic [31:0] data;
  logic [3:0]  wmask;

  modport master (output valid, addr, data, wmask, input ready);
  modport slave  (input valid, addr, data, wmask, output ready);

endinterface

// File: rtl/sq_fwd_select.sv
// Per-byte store-to-load forwarding priority. Walks the slots from the queue head
// (oldest) towards the tail, letting each younger matching store overwrite the
// bytes it writes, so every byte ends up sourced from the youngest matching store.
//   match_i  per-slot hit (valid, same word, older than the load)
//   wmask_i  per-slot byte enables
//   data_i   per-slot store data
//   head_i   slot index of the oldest entry
//   mask_o   bytes supplied by some store
//   data_o   forwarded bytes (zero outside mask_o)
module sq_fwd_select #(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic [NUM_ENTRIES-1:0]            match_i,
  input  logic [NUM_ENTRIES-1:0][3:0]       wmask_i,
  input  logic [NUM_ENTRIES-1:0][31:0]      data_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0]    head_i,
  output logic [3:0]                        mask_o,
  output logic [31:0]                       data_o
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

  logic [IdxW-1:0] slot;

  always_comb begin
    mask_o = '0;
    data_o = '0;
    slot   = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      slot = head_i + IdxW'(k);
      if (match_i[slot]) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask_i[slot][b]) begin
            mask_o[b]        = 1'b1;
            data_o[8*b +: 8] = data_i[slot][8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Store queue: holds AGU stores until the ROB commits them, drains committed stores
// in order to the data-memory write port, and forwards store bytes to younger loads
// with a one-cycle registered result.
//   clk, rst          clock, synchronous active-high reset
//   uop_i             AGU output (stores enqueue, loads look up)
//   branch_i          mispredict flush
//   com_valid_i       commit pulse; com_sqn_i = youngest committed sqN
//   mem_if            memory write port (master)
//   fwd_valid_o/mask_o/data_o  registered forwarding result
//   max_store_sqn_o   youngest storeSqN that currently has a free slot
module store_queue
  import store_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = SQ_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  AGU_UOp               uop_i,
  input  BranchProv            branch_i,
  input  logic                 com_valid_i,
  input  SqN                   com_sqn_i,
  store_queue_if.master        mem_if,
  output logic                 fwd_valid_o,
  output logic [3:0]           fwd_mask_o,
  output logic [31:0]          fwd_data_o,
  output SqN                   max_store_sqn_o
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  typedef logic [IdxW-1:0] idx_t;

  SQEntry      sq_q [NUM_ENTRIES];
  SQEntry      sq_d [NUM_ENTRIES];
  SqN          head_q, head_d;
  logic        fwd_valid_q, fwd_valid_d;
  logic [3:0]  fwd_mask_q, fwd_mask_d;
  logic [31:0] fwd_data_q, fwd_data_d;

  idx_t   head_idx, enq_idx;
  SQEntry head_entry;
  logic   mem_valid, drain, uop_flushed, enq, lookup;

  logic [NUM_ENTRIES-1:0]       fwd_match;
  logic [NUM_ENTRIES-1:0][3:0]  slot_wmask;
  logic [NUM_ENTRIES-1:0][31:0] slot_data;
  logic [3:0]                   sel_mask;
  logic [31:0]                  sel_data;

  logic unused_bits;
  assign unused_bits = ^{uop_i.addr[1:0], branch_i.storeSqN};

  assign head_idx   = head_q[IdxW-1:0];
  assign enq_idx    = uop_i.storeSqN[IdxW-1:0];
  assign head_entry = sq_q[head_idx];

  assign mem_valid     = head_entry.valid && head_entry.committed;
  assign drain         = mem_valid && mem_if.ready;
  assign mem_if.valid  = mem_valid;
  assign mem_if.addr   = mem_valid ? head_entry.addr  : '0;
  assign mem_if.data   = mem_valid ? head_entry.data  : '0;
  assign mem_if.wmask  = mem_valid ? head_entry.wmask : '0;

  assign max_store_sqn_o = head_q + SqN'(NUM_ENTRIES - 1);

  assign uop_flushed = branch_i.taken && sqn_after(uop_i.sqN, branch_i.sqN);
  assign enq    = uop_i.valid && !uop_i.isLoad && !uop_i.exception && !uop_flushed;
  assign lookup = uop_i.valid && uop_i.isLoad && !uop_flushed;

  // Lookup sees only the registered slots; a same-cycle store is replayed downstream.
  always_comb begin
    fwd_match  = '0;
    slot_wmask = '0;
    slot_data  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      fwd_match[i]  = sq_q[i].valid && (sq_q[i].addr == uop_i.addr[31:2]) &&
                      sqn_before(sq_q[i].sqN, uop_i.sqN);
      slot_wmask[i] = sq_q[i].wmask;
      slot_data[i]  = sq_q[i].data;
    end
  end

  sq_fwd_select #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_fwd_select (
    .match_i (fwd_match),
    .wmask_i (slot_wmask),
    .data_i  (slot_data),
    .head_i  (head_idx),
    .mask_o  (sel_mask),
    .data_o  (sel_data)
  );

  always_comb begin
    sq_d   = sq_q;
    head_d = head_q;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (com_valid_i && sq_q[i].valid && !sqn_after(sq_q[i].sqN, com_sqn_i)) begin
        sq_d[i].committed = 1'b1;
      end
      // Uses the post-commit flag so a store committed this cycle is never flushed.
      if (branch_i.taken && sq_d[i].valid && !sq_d[i].committed &&
          sqn_after(sq_q[i].sqN, branch_i.sqN)) begin
        sq_d[i].valid = 1'b0;
      end
    end

    if (drain) begin
      sq_d[head_idx] = '0;
      head_d         = head_q + SqN'(1);
    end

    if (enq) begin
      sq_d[enq_idx] = '{valid:     1'b1,
                        committed: 1'b0,
                        sqN:       uop_i.sqN,
                        addr:      uop_i.addr[31:2],
                        data:      uop_i.data,
                        wmask:     uop_i.wmask};
    end

    fwd_valid_d = lookup;
    fwd_mask_d  = lookup ? sel_mask : '0;
    fwd_data_d  = lookup ? sel_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        sq_q[i] <= '0;
      end
      head_q      <= '0;
      fwd_valid_q <= 1'b0;
      fwd_mask_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      sq_q        <= sq_d;
      head_q      <= head_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_mask_q  <= fwd_mask_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwd_valid_o = fwd_valid_q;
  assign fwd_mask_o  = fwd_mask_q;
  assign fwd_data_o  = fwd_data_q;

`ifndef SYNTHESIS
  // Rename must stall stores that have no slot; overrunning would clobber a live entry.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      assert (!sqn_after(uop_i.storeSqN, max_store_sqn_o))
        else $error("store_queue: storeSqN %0d beyond max %0d",
                    uop_i.storeSqN, max_store_sqn_o);
    end
  end
`endif

endmodule
